// File: rtl/tlb_ptw.sv
// tlb_ptw: two-level Sv32-style page table walker with a single-outstanding PTE read port.
// Optional build macro PTW_AD_CHECK_EN: report leaf PTEs with the accessed bit clear as faults.
//
// state   | meaning
// IDLE    | ready for a walk request
// L1_REQ  | issuing the level-1 PTE read
// L1_WAIT | waiting for the level-1 PTE
// L0_REQ  | issuing the level-0 PTE read
// L0_WAIT | waiting for the level-0 PTE
// RESP    | holding the walk result until the TLB takes it
module tlb_ptw #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] satp_ppn_i,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [19:0] ptw_req_vpn_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [19:0] ptw_resp_ppn_o,
  output logic [7:0]  ptw_resp_perm_o,
  output logic        ptw_resp_super_o,
  output logic        ptw_resp_fault_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_t;

  state_t        state;
  logic [9:0]    vpn0;
  logic [CW-1:0] cnt;

  logic [7:0]    flags;
  logic          pte_bad, pte_leaf, ad_bad, timed_out;
  logic          done, descend, r_fault, r_super;
  logic [19:0]   r_ppn;
  logic [7:0]    r_perm;
  logic          unused_bits;

  assign unused_bits = ^{mem_resp_data_i[31:30], mem_resp_data_i[9:8]};

  assign flags     = mem_resp_data_i[7:0];
  assign pte_bad   = ~flags[0] | (~flags[1] & flags[2]);
  assign pte_leaf  = flags[1] | flags[3];
  assign timed_out = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 1);

`ifdef PTW_AD_CHECK_EN
  assign ad_bad = ~flags[6];
`else
  assign ad_bad = 1'b0;
`endif

  // Classify the returned PTE; a response in the timeout cycle takes priority.
  always_comb begin
    done    = 1'b0;
    descend = 1'b0;
    r_fault = 1'b0;
    r_super = 1'b0;
    r_ppn   = '0;
    r_perm  = flags;
    if (state == L1_WAIT || state == L0_WAIT) begin
      if (mem_resp_valid_i) begin
        done = 1'b1;
        if (pte_bad) begin
          r_fault = 1'b1;
        end else if (!pte_leaf) begin
          if (state == L1_WAIT) begin
            done    = 1'b0;
            descend = 1'b1;
          end else begin
            r_fault = 1'b1;
          end
        end else if (ad_bad || (state == L1_WAIT && mem_resp_data_i[19:10] != 10'd0)) begin
          r_fault = 1'b1;
        end else if (state == L1_WAIT) begin
          r_ppn   = {mem_resp_data_i[29:20], vpn0};
          r_super = 1'b1;
        end else begin
          r_ppn = mem_resp_data_i[29:10];
        end
      end else if (timed_out) begin
        done    = 1'b1;
        r_fault = 1'b1;
        r_perm  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vpn0             <= '0;
      cnt              <= '0;
      ptw_req_ready_o  <= 1'b1;
      ptw_resp_valid_o <= 1'b0;
      ptw_resp_ppn_o   <= '0;
      ptw_resp_perm_o  <= '0;
      ptw_resp_super_o <= 1'b0;
      ptw_resp_fault_o <= 1'b0;
      mem_req_valid_o  <= 1'b0;
      mem_req_addr_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ptw_req_valid_i && ptw_req_ready_o) begin
            vpn0            <= ptw_req_vpn_i[9:0];
            ptw_req_ready_o <= 1'b0;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= {satp_ppn_i, ptw_req_vpn_i[19:10], 2'b00};
            state           <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            cnt             <= '0;
            state           <= (state == L1_REQ) ? L1_WAIT : L0_WAIT;
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (descend) begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= {mem_resp_data_i[29:10], vpn0, 2'b00};
            state           <= L0_REQ;
          end else if (done) begin
            ptw_resp_valid_o <= 1'b1;
            ptw_resp_fault_o <= r_fault;
            ptw_resp_ppn_o   <= r_ppn;
            ptw_resp_perm_o  <= r_perm;
            ptw_resp_super_o <= r_super;
            state            <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (ptw_resp_ready_i) begin
            ptw_resp_valid_o <= 1'b0;
            ptw_resp_fault_o <= 1'b0;
            ptw_req_ready_o  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ptw.sv
// tb_tlb_ptw: scoreboard bench for tlb_ptw; expected walk results are queued at request time.
// Honours PTW_AD_CHECK_EN the same way the design does.
module tb_tlb_ptw;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] satp_ppn;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        resp_valid;
  logic        resp_ready;
  logic [19:0] resp_ppn;
  logic [7:0]  resp_perm;
  logic        resp_super;
  logic        resp_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a0;
    logic        two;
    logic [19:0] ppn;
    logic [7:0]  perm;
    logic        sup;
    logic        flt;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tlb_ptw #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .satp_ppn_i       (satp_ppn),
    .ptw_req_valid_i  (req_valid),
    .ptw_req_ready_o  (req_ready),
    .ptw_req_vpn_i    (req_vpn),
    .ptw_resp_valid_o (resp_valid),
    .ptw_resp_ready_i (resp_ready),
    .ptw_resp_ppn_o   (resp_ppn),
    .ptw_resp_perm_o  (resp_perm),
    .ptw_resp_super_o (resp_super),
    .ptw_resp_fault_o (resp_fault),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit pte_bad(input logic [7:0] f);
    return !f[0] || (!f[1] && f[2]);
  endfunction

  function automatic bit ad_fault(input logic [7:0] f);
`ifdef PTW_AD_CHECK_EN
    return !f[6];
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model(input logic [19:0] root, input logic [19:0] vpn,
                                 input logic [31:0] p1, input logic [31:0] p2,
                                 input bit no_resp, input int stall);
    exp_t e;
    logic [7:0] f, g;
    f = p1[7:0];
    g = p2[7:0];
    e.a1 = {root, vpn[19:10], 2'b00};
    e.a0 = '0;
    e.two = 1'b0;
    e.ppn = '0;
    e.perm = '0;
    e.sup = 1'b0;
    e.flt = 1'b0;
    if (no_resp) begin
      e.flt = 1'b1;
    end else if (pte_bad(f)) begin
      e.flt = 1'b1;
      e.perm = f;
    end else if (f[1] | f[3]) begin
      e.perm = f;
      if (p1[19:10] != 10'd0 || ad_fault(f)) e.flt = 1'b1;
      else begin
        e.ppn = {p1[29:20], vpn[9:0]};
        e.sup = 1'b1;
      end
    end else begin
      e.two = 1'b1;
      e.a0 = {p1[29:10], vpn[9:0], 2'b00};
      e.perm = g;
      if (pte_bad(g) || !(g[1] | g[3]) || ad_fault(g)) e.flt = 1'b1;
      else e.ppn = p2[29:10];
    end
    e.lat = no_resp ? int'(TO) + 1 + stall : (e.two ? 4 : 2) + stall;
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_ppn"}, 32'(resp_ppn), 0);
    chk({tag, "_perm"}, 32'(resp_perm), 0);
    chk({tag, "_super"}, 32'(resp_super), 0);
    chk({tag, "_fault"}, 32'(resp_fault), 0);
    chk({tag, "_mem_valid"}, 32'(mem_req_valid), 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
  endtask

  // One complete walk: request, memory service, result check, optional result backpressure.
  task automatic do_walk(input string tag, input logic [19:0] root, input logic [19:0] vpn,
                         input logic [31:0] p1, input logic [31:0] p2, input bit no_resp,
                         input int req_stall, input int resp_stall);
    exp_t e;
    int lvl, stall_left, cyc;
    bit acc, stalled, got;
    string at;
    sb.push_back(model(root, vpn, p1, p2, no_resp, req_stall));
    e = sb[sb.size() - 1];
    chk({tag, "_idle_ready"}, 32'(req_ready), 1);
    satp_ppn = root;
    req_vpn = vpn;
    req_valid = 1'b1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    satp_ppn = '0;
    req_vpn = '0;
    chk({tag, "_busy_ready"}, 32'(req_ready), 0);
    lvl = 1;
    stall_left = req_stall;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (mem_req_valid) begin
        at = (lvl == 1) ? {tag, "_a1"} : {tag, "_a0"};
        chk(at, mem_req_addr, (lvl == 1) ? e.a1 : e.a0);
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
      acc = mem_req_valid && mem_req_ready;
      stalled = mem_req_valid && !mem_req_ready;
      @(posedge clk); #1;
      cyc++;
      mem_resp_valid = 1'b0;
      if (stalled) chk({tag, "_vhold"}, 32'(mem_req_valid), 1);
      if (acc) begin
        if (!no_resp) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = (lvl == 1) ? p1 : p2;
        end
        lvl++;
      end
      if (resp_valid) got = 1'b1;
    end
    mem_req_ready = 1'b0;
    if (!got) begin
      chk({tag, "_bound"}, 0, 1);
      void'(sb.pop_front());
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      chk({tag, "_fault"}, 32'(resp_fault), 32'(e.flt));
      chk({tag, "_ppn"}, 32'(resp_ppn), 32'(e.ppn));
      chk({tag, "_perm"}, 32'(resp_perm), 32'(e.perm));
      chk({tag, "_super"}, 32'(resp_super), 32'(e.sup));
      if (resp_stall > 0) begin
        req_valid = 1'b1;
        satp_ppn = 20'hABCDE;
        req_vpn = 20'h12345;
      end
      for (int i = 0; i < resp_stall; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, 32'(resp_valid), 1);
        chk({tag, "_hold_ppn"}, 32'(resp_ppn), 32'(e.ppn));
        chk({tag, "_hold_perm"}, 32'(resp_perm), 32'(e.perm));
        chk({tag, "_hold_fault"}, 32'(resp_fault), 32'(e.flt));
        chk({tag, "_hold_super"}, 32'(resp_super), 32'(e.sup));
        chk({tag, "_hold_ready"}, 32'(req_ready), 0);
        chk({tag, "_hold_mem"}, 32'(mem_req_valid), 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "_done_valid"}, 32'(resp_valid), 0);
      chk({tag, "_done_fault"}, 32'(resp_fault), 0);
      chk({tag, "_done_ready"}, 32'(req_ready), 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    satp_ppn = '0;
    req_valid = 1'b0;
    req_vpn = '0;
    resp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    do_walk("two_lvl",  20'h00010, 20'h00403, 32'h00008001, 32'h000450CF, 1'b0, 0, 0);
    do_walk("super",    20'h00010, 20'h12345, 32'h2000000F, 32'h0,        1'b0, 0, 0);
    do_walk("misalign", 20'h00010, 20'h12345, 32'h2000040F, 32'h0,        1'b0, 0, 0);
    do_walk("l1_zero",  20'h00010, 20'h00403, 32'h00000000, 32'h0,        1'b0, 0, 0);
    do_walk("l0_ptr",   20'h00010, 20'h00403, 32'h00008001, 32'h00000001, 1'b0, 0, 0);
    do_walk("w_only",   20'h00010, 20'h00403, 32'h00000005, 32'h0,        1'b0, 0, 0);
    do_walk("ad_leaf",  20'h00010, 20'h00403, 32'h00008001, 32'h0004500F, 1'b0, 0, 0);
    do_walk("bp",       20'h00010, 20'h00403, 32'h00008001, 32'h000450CF, 1'b0, 3, 5);

    do_walk("tmo",      20'h00033, 20'h00C07, 32'h0,        32'h0,        1'b1, 0, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h000450CF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("late_resp_valid", 32'(resp_valid), 0);
    chk("late_mem_valid", 32'(mem_req_valid), 0);
    chk("late_ready", 32'(req_ready), 1);
    do_walk("after_tmo", 20'h00010, 20'h00403, 32'h00008001, 32'h000450CF, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [19:0] root, vpn;
      logic [31:0] p1, p2;
      root = 20'($urandom);
      vpn = 20'($urandom);
      if (i % 2 == 0) begin
        p1 = {2'b00, 20'($urandom), 10'h001};
        p2 = {2'b00, 20'($urandom), 2'b00, 8'hC7};
      end else begin
        p1 = {2'b00, 10'($urandom), 10'h000, 2'b00, 8'hCB};
        p2 = '0;
      end
      do_walk("rand", root, vpn, p1, p2, 1'b0, i % 3, i % 2);
    end

    // Reset while waiting for the level-0 PTE.
    mem_req_ready = 1'b1;
    satp_ppn = 20'h00010;
    req_vpn = 20'h00403;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h00008001;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("mid_a0", mem_req_addr, 32'h0002000C);
    @(posedge clk); #1;
    chk("mid_in_wait", 32'(mem_req_valid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("mid_rst");
    rst = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h000450CF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_valid", 32'(resp_valid), 0);
      @(posedge clk); #1;
    end
    chk("post_rst_ready", 32'(req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
